// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared types and widths for the main-memory responder
package main_mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} mm_state_t;
  localparam int MM_CNT_W = 8;
  localparam int MM_STAT_W = 16;
  function automatic logic [MM_STAT_W-1:0] sat_inc(input logic [MM_STAT_W-1:0] v);
    return (v == {MM_STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/mm_sp_array.sv
// mm_sp_array: synchronous single-port array; read data registered, held across writes
module mm_sp_array #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
    if (en && !we) rdata_q <= mem[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency single-word memory target for direct_cache
// refill and write-back traffic, with saturating access statistics.
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_main,
  input  logic                  addr_main_en,
  input  logic [DATA_WIDTH-1:0] data_main,
  input  logic                  data_main_vld,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_vld,
  output logic                  wr_done,
  output logic                  mem_busy,
  output logic [MM_STAT_W-1:0]  rd_count,
  output logic [MM_STAT_W-1:0]  wr_count
);
  mm_state_t             state_q, state_d;
  logic [MM_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, arr_rdata;
  logic                  we_q, we_d, accept, fire, resp;
  logic [MM_STAT_W-1:0]  rd_count_q, rd_count_d, wr_count_q, wr_count_d;

  mm_sp_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clk  (clk),
    .en   (fire),
    .we   (we_q),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  always_comb begin
    resp       = state_q == RESP;
    accept     = state_q != ACCESS && addr_main_en;
    fire       = state_q == ACCESS && cnt_q == '0;
    state_d    = resp ? IDLE : state_q;
    cnt_d      = state_q == ACCESS ? cnt_q - 1'b1 : cnt_q;
    addr_d     = accept ? addr_main : addr_q;
    wdata_d    = accept ? data_main : wdata_q;
    we_d       = accept ? data_main_vld : we_q;
    rd_count_d = fire && !we_q ? sat_inc(rd_count_q) : rd_count_q;
    wr_count_d = fire && we_q ? sat_inc(wr_count_q) : wr_count_q;
    rdata_d    = resp && !we_q ? arr_rdata : rdata_q;
    if (accept) begin
      state_d = ACCESS;
      cnt_d   = MM_CNT_W'(LATENCY - 1);
    end
    if (fire) state_d = RESP;
  end

  // Array contents are deliberately outside this reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rdata     = rdata_d;
  assign rdata_vld = state_q == RESP && !we_q;
  assign wr_done   = state_q == RESP && we_q;
  assign mem_busy  = state_q == ACCESS;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed checks of latency, data, back-to-back, reset abort and saturation
module tb_main_mem_responder;
  logic        clk = 0, rst_n = 0;
  logic [15:0] addr = 0;
  logic [7:0]  wdata = 0;
  logic        we = 0, en4 = 0, en1 = 0;
  logic [7:0]  rdata4, rdata1;
  logic        vld4, done4, busy4, vld1, done1, busy1;
  logic [15:0] rc4, wc4, rc1, wc1;
  int checks = 0, errors = 0;
  int n;
  bit bad;

  main_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .addr_main(addr), .addr_main_en(en4), .data_main(wdata),
    .data_main_vld(we), .rdata(rdata4), .rdata_vld(vld4), .wr_done(done4), .mem_busy(busy4),
    .rd_count(rc4), .wr_count(wc4));

  main_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .addr_main(addr), .addr_main_en(en1), .data_main(wdata),
    .data_main_vld(we), .rdata(rdata1), .rdata_vld(vld1), .wr_done(done1), .mem_busy(busy1),
    .rd_count(rc1), .wr_count(wc1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w, input bit d1);
    @(negedge clk);
    addr = a; wdata = d; we = w;
    if (d1) en1 = 1; else en4 = 1;
    @(posedge clk); #1;
    en4 = 0; en1 = 0;
  endtask

  task automatic wait_ev(input bit d1, output int cnt, output bit busy_bad);
    logic st, b, ov;
    cnt = 0; busy_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      st = d1 ? (vld1 | done1) : (vld4 | done4);
      ov = d1 ? (vld1 & done1) : (vld4 & done4);
      b  = d1 ? busy1 : busy4;
      if (st == b || ov) busy_bad = 1;
      if (st) begin cnt = i; break; end
    end
  endtask

  task automatic idle(input int cyc, input bit d1, output int cnt);
    cnt = 0;
    repeat (cyc) begin
      @(posedge clk); #1;
      if (d1 ? (vld1 | done1) : (vld4 | done4)) cnt++;
    end
  endtask

  task automatic xact(input string tag, input logic [15:0] a, input logic [7:0] d,
                      input logic w, input bit d1, input int lat);
    int c;
    bit bb;
    drive(a, d, w, d1);
    chk({tag, "_busy_after_accept"}, d1 ? busy1 : busy4, 1);
    wait_ev(d1, c, bb);
    chk({tag, "_latency"}, c, lat);
    chk({tag, "_busy_profile"}, bb, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_rdata", rdata4, 0);
    chk("rst_vld", vld4, 0);
    chk("rst_done", done4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_rc", rc4, 0);
    chk("rst_wc", wc4, 0);
    idle(20, 0, n);
    chk("idle_no_strobe", n, 0);

    xact("wr5a", 16'h1234, 8'h5A, 1, 0, 4);
    chk("wr5a_done", done4, 1);
    chk("wr5a_not_vld", vld4, 0);
    chk("wr5a_busy_resp", busy4, 0);
    chk("wr5a_wc", wc4, 1);

    xact("rd5a", 16'h1234, 8'h00, 0, 0, 4);
    chk("rd5a_vld", vld4, 1);
    chk("rd5a_data", rdata4, 8'h5A);
    chk("rd5a_rc", rc4, 1);
    @(posedge clk); #1;
    chk("rd5a_vld_drop", vld4, 0);
    chk("rd5a_data_hold", rdata4, 8'h5A);

    @(negedge clk);
    addr = 16'h0001; wdata = 8'h11; we = 1; en4 = 1;
    @(posedge clk);
    @(negedge clk);
    we = 0; wdata = 8'hEE;
    wait_ev(0, n, bad);
    chk("b2b_wr_latency", n, 4);
    chk("b2b_wr_done", done4, 1);
    @(posedge clk); #1;
    en4 = 0;
    chk("b2b_rd_accepted", busy4, 1);
    wait_ev(0, n, bad);
    chk("b2b_rd_gap", n + 1, 5);
    chk("b2b_rd_vld", vld4, 1);
    chk("b2b_rd_data", rdata4, 8'h11);
    idle(10, 0, n);
    chk("b2b_no_extra", n, 0);
    chk("b2b_rc", rc4, 2);
    chk("b2b_wc", wc4, 2);

    xact("wr77", 16'h0010, 8'h77, 1, 0, 4);
    chk("wr77_wc", wc4, 3);
    drive(16'h0010, 8'h99, 1, 0);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("abort_busy", busy4, 0);
    chk("abort_wc", wc4, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle(10, 0, n);
    chk("abort_no_strobe", n, 0);
    chk("abort_wc_after", wc4, 0);
    xact("rd77", 16'h0010, 8'h00, 0, 0, 4);
    chk("rd77_data", rdata4, 8'h77);
    chk("rd77_rc", rc4, 1);

    xact("l1_wr", 16'h1234, 8'hA5, 1, 1, 1);
    chk("l1_wr_done", done1, 1);
    @(negedge clk);
    force dut1.rd_count_q = 16'hFFFE;
    @(negedge clk);
    release dut1.rd_count_q;
    chk("l1_forced", rc1, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      xact("l1_rd", 16'h1234, 8'h00, 0, 1, 1);
      chk("l1_rd_data", rdata1, 8'hA5);
      chk("l1_rd_sat", rc1, 16'hFFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
